// File: rtl/tft_rect_fill.sv
// Rectangle-fill byte generator for tft_spi: emits CASET/PASET/RAMWR and N
// copies of an RGB565 colour using the tft_data/tft_dc/tft_transmit/tft_busy handshake.
module tft_rect_fill #(
   parameter int unsigned WIDTH  = 240,
   parameter int unsigned HEIGHT = 320
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic [8:0]  i_x0,
   input  logic [8:0]  i_x1,
   input  logic [8:0]  i_y0,
   input  logic [8:0]  i_y1,
   input  logic [15:0] i_colour,
   input  logic        i_tft_busy,
   output logic [7:0]  o_tft_data,
   output logic        o_tft_dc,
   output logic        o_tft_transmit,
   output logic        o_busy,
   output logic        o_done
);

   localparam int unsigned CW       = 9;
   localparam int unsigned IW       = 4;
   localparam logic [CW-1:0] XMAX   = CW'(WIDTH - 1);
   localparam logic [CW-1:0] YMAX   = CW'(HEIGHT - 1);
   localparam logic [IW-1:0] IDX_PIX = IW'(11);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SEND,
      S_WAIT,
      S_DONE
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_x0, r_x1, r_y0, r_y1;
   logic [CW-1:0]   r_col, r_row;
   logic [15:0]     r_colour;
   logic [IW-1:0]   r_idx;
   logic            r_phase;
   logic            r_guard;
   logic [7:0]      r_tft_data;
   logic            r_tft_dc;
   logic            r_tft_transmit;
   logic            r_busy;
   logic            r_done;

   logic [CW-1:0]   w_x0c, w_x1c, w_y0c, w_y1c;
   logic            w_reject;
   logic            w_last;
   logic [7:0]      w_byte;
   logic            w_dc;

   // Clamp latched bounds to the panel; used only in LOAD.
   assign w_x0c    = (r_x0 > XMAX) ? XMAX : r_x0;
   assign w_x1c    = (r_x1 > XMAX) ? XMAX : r_x1;
   assign w_y0c    = (r_y0 > YMAX) ? YMAX : r_y0;
   assign w_y1c    = (r_y1 > YMAX) ? YMAX : r_y1;
   assign w_reject = (w_x0c > w_x1c) || (w_y0c > w_y1c);
   assign w_last   = r_phase && (r_col == r_x1) && (r_row == r_y1);

   // Current byte: 11 header bytes, then colour hi/lo per pixel.
   always_comb begin
      w_byte = 8'h00;
      w_dc   = 1'b1;
      case (r_idx)
         IW'(0):  begin w_byte = 8'h2A; w_dc = 1'b0; end
         IW'(1):  w_byte = {7'b0, r_x0[8]};
         IW'(2):  w_byte = r_x0[7:0];
         IW'(3):  w_byte = {7'b0, r_x1[8]};
         IW'(4):  w_byte = r_x1[7:0];
         IW'(5):  begin w_byte = 8'h2B; w_dc = 1'b0; end
         IW'(6):  w_byte = {7'b0, r_y0[8]};
         IW'(7):  w_byte = r_y0[7:0];
         IW'(8):  w_byte = {7'b0, r_y1[8]};
         IW'(9):  w_byte = r_y1[7:0];
         IW'(10): begin w_byte = 8'h2C; w_dc = 1'b0; end
         default: w_byte = r_phase ? r_colour[7:0] : r_colour[15:8];
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state        <= S_IDLE;
         r_x0           <= '0;
         r_x1           <= '0;
         r_y0           <= '0;
         r_y1           <= '0;
         r_col          <= '0;
         r_row          <= '0;
         r_colour       <= '0;
         r_idx          <= '0;
         r_phase        <= 1'b0;
         r_guard        <= 1'b0;
         r_tft_data     <= '0;
         r_tft_dc       <= 1'b0;
         r_tft_transmit <= 1'b0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (i_start) begin
                  r_x0     <= i_x0;
                  r_x1     <= i_x1;
                  r_y0     <= i_y0;
                  r_y1     <= i_y1;
                  r_colour <= i_colour;
                  r_busy   <= 1'b1;
                  r_state  <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (w_reject) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_x0    <= w_x0c;
                  r_x1    <= w_x1c;
                  r_y0    <= w_y0c;
                  r_y1    <= w_y1c;
                  r_col   <= w_x0c;
                  r_row   <= w_y0c;
                  r_idx   <= '0;
                  r_phase <= 1'b0;
                  r_state <= S_SEND;
               end
            end
            S_SEND: begin
               if (!i_tft_busy) begin
                  r_tft_data     <= w_byte;
                  r_tft_dc       <= w_dc;
                  r_tft_transmit <= 1'b1;
                  r_guard        <= 1'b1;
                  r_state        <= S_WAIT;
               end
            end
            S_WAIT: begin
               r_tft_transmit <= 1'b0;
               // First WAIT cycle gives tft_spi time to raise busy.
               if (r_guard) begin
                  r_guard <= 1'b0;
               end else if (!i_tft_busy) begin
                  if (r_idx != IDX_PIX) begin
                     r_idx   <= r_idx + IW'(1);
                     r_state <= S_SEND;
                  end else if (w_last) begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_state <= S_SEND;
                     if (!r_phase) begin
                        r_phase <= 1'b1;
                     end else begin
                        r_phase <= 1'b0;
                        if (r_col == r_x1) begin
                           r_col <= r_x0;
                           r_row <= r_row + CW'(1);
                        end else begin
                           r_col <= r_col + CW'(1);
                        end
                     end
                  end
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_tft_data     = r_tft_data;
   assign o_tft_dc       = r_tft_dc;
   assign o_tft_transmit = r_tft_transmit;
   assign o_busy         = r_busy;
   assign o_done         = r_done;

endmodule

// File: tb/tb_tft_rect_fill.sv
// Directed bench for tft_rect_fill with a tft_spi busy model and a byte-stream monitor.
module tb_tft_rect_fill;

   logic        clk;
   logic        rst;
   logic        start;
   logic [8:0]  x0, x1, y0, y1;
   logic [15:0] colour;
   logic        tft_busy;
   logic [7:0]  tft_data;
   logic        tft_dc;
   logic        tft_transmit;
   logic        busy;
   logic        done;

   int          total;
   int          bad;
   int          cyc;
   int          spi_k;
   int          spi_cnt;
   int          done_cnt;
   int          done_cyc;
   int          busy_viol;
   int          hold_err;
   int          done_busy_err;
   logic [8:0]  last_out;
   logic [8:0]  q_bytes[$];
   int          q_cyc[$];

   tft_rect_fill dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_start        (start),
      .i_x0           (x0),
      .i_x1           (x1),
      .i_y0           (y0),
      .i_y1           (y1),
      .i_colour       (colour),
      .i_tft_busy     (tft_busy),
      .o_tft_data     (tft_data),
      .o_tft_dc       (tft_dc),
      .o_tft_transmit (tft_transmit),
      .o_busy         (busy),
      .o_done         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // tft_spi stand-in: busy for spi_k cycles after each strobe.
   always @(posedge clk) begin
      if (!rst)                 spi_cnt <= 0;
      else if (tft_transmit)    spi_cnt <= spi_k;
      else if (spi_cnt != 0)    spi_cnt <= spi_cnt - 1;
   end
   assign tft_busy = (spi_cnt != 0);

   always @(negedge clk) begin
      if (tft_transmit) begin
         q_bytes.push_back({tft_dc, tft_data});
         q_cyc.push_back(cyc);
         if (tft_busy) busy_viol++;
      end
      if (rst && !tft_transmit && ({tft_dc, tft_data} !== last_out)) hold_err++;
      last_out = {tft_dc, tft_data};
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
         if (busy) done_busy_err++;
      end
   end

   task automatic pulse_start(input logic [8:0] a0, input logic [8:0] a1,
                              input logic [8:0] b0, input logic [8:0] b1,
                              input logic [15:0] c);
      x0 = a0; x1 = a1; y0 = b0; y1 = b1; colour = c; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      x0 = 9'h1FF; x1 = 9'h000; y0 = 9'h1FF; y1 = 9'h000; colour = 16'hDEAD;
   endtask

   task automatic wait_done(input int budget, input string name);
      int d0;
      int n;
      d0 = done_cnt;
      n  = 0;
      while (done_cnt == d0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      total++;
      if (done_cnt == d0) begin
         bad++;
         $display("FAIL %s: done not seen within %0d cycles", name, budget);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_hdr(input string name, input logic [8:0] exp[11]);
      logic [8:0] got;
      for (int i = 0; i < 11; i++) begin
         got = (q_bytes.size() > i) ? q_bytes[i] : 9'h1FF;
         total++;
         if (got !== exp[i]) begin
            bad++;
            $display("FAIL %s byte%0d: got dc/data %h expected %h", name, i, got, exp[i]);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_int("reset_transmit", int'(tft_transmit), 0);
      check_int("reset_data",     int'(tft_data), 0);
      check_int("reset_dc",       int'(tft_dc), 0);
      check_int("reset_busy",     int'(busy), 0);
      check_int("reset_done",     int'(done), 0);
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_single_pixel();
      logic [8:0] hdr[11];
      int d0;
      hdr = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h100,
              9'h02B, 9'h100, 9'h100, 9'h100, 9'h100, 9'h02C};
      q_bytes.delete(); q_cyc.delete();
      spi_k = 3;
      d0 = done_cnt;
      pulse_start(9'd0, 9'd0, 9'd0, 9'd0, 16'hF800);
      check_int("px1_busy_rise", int'(busy), 1);
      wait_done(2000, "px1_done");
      check_int("px1_count", q_bytes.size(), 13);
      check_hdr("px1", hdr);
      check_int("px1_col_hi", (q_bytes.size() > 11) ? int'(q_bytes[11]) : -1, 9'h1F8);
      check_int("px1_col_lo", (q_bytes.size() > 12) ? int'(q_bytes[12]) : -1, 9'h100);
      repeat (10) @(posedge clk);
      @(negedge clk);
      check_int("px1_done_pulses", done_cnt - d0, 1);
      check_int("px1_busy_at_done", done_busy_err, 0);
      check_int("px1_busy_after", int'(busy), 0);
   endtask

   task automatic test_clamp_stripe();
      logic [8:0] hdr[11];
      int         bad_px;
      hdr = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h1EF,
              9'h02B, 9'h101, 9'h12C, 9'h101, 9'h13F, 9'h02C};
      q_bytes.delete(); q_cyc.delete();
      spi_k = 1;
      pulse_start(9'd0, 9'd500, 9'd300, 9'd319, 16'h001F);
      wait_done(60000, "stripe_done");
      check_int("stripe_count", q_bytes.size(), 9611);
      check_hdr("stripe", hdr);
      bad_px = 0;
      for (int i = 11; i < q_bytes.size(); i++)
         if (q_bytes[i] !== (((i - 11) % 2 == 0) ? 9'h100 : 9'h11F)) bad_px++;
      check_int("stripe_pixel_bytes", bad_px, 0);
      check_int("stripe_last", (q_bytes.size() > 0) ? int'(q_bytes[q_bytes.size()-1]) : -1, 9'h11F);
   endtask

   task automatic test_clamp_corner();
      logic [8:0] hdr[11];
      hdr = '{9'h02A, 9'h100, 9'h1EF, 9'h100, 9'h1EF,
              9'h02B, 9'h101, 9'h13F, 9'h101, 9'h13F, 9'h02C};
      q_bytes.delete(); q_cyc.delete();
      spi_k = 2;
      pulse_start(9'd400, 9'd500, 9'd350, 9'd511, 16'hA5C3);
      wait_done(2000, "corner_done");
      check_int("corner_count", q_bytes.size(), 13);
      check_hdr("corner", hdr);
      check_int("corner_col_lo", (q_bytes.size() > 12) ? int'(q_bytes[12]) : -1, 9'h1C3);
   endtask

   task automatic test_reject();
      int t0;
      q_bytes.delete(); q_cyc.delete();
      t0 = cyc;
      pulse_start(9'd10, 9'd5, 9'd0, 9'd0, 16'h1111);
      wait_done(10, "rej_x_done");
      check_int("rej_x_latency_ok", int'((done_cyc - t0) <= 3), 1);
      check_int("rej_x_strobes", q_bytes.size(), 0);
      check_int("rej_x_busy", int'(busy), 0);
      pulse_start(9'd300, 9'd100, 9'd0, 9'd0, 16'h2222);
      wait_done(10, "rej_clamp_done");
      check_int("rej_clamp_strobes", q_bytes.size(), 0);
      pulse_start(9'd0, 9'd0, 9'd50, 9'd49, 16'h3333);
      wait_done(10, "rej_y_done");
      check_int("rej_y_strobes", q_bytes.size(), 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_int("rej_busy_after", int'(busy), 0);
   endtask

   task automatic test_slow_spi();
      logic [8:0] hdr[11];
      int min_gap;
      hdr = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h100,
              9'h02B, 9'h100, 9'h100, 9'h100, 9'h100, 9'h02C};
      q_bytes.delete(); q_cyc.delete();
      spi_k = 17;
      pulse_start(9'd0, 9'd0, 9'd0, 9'd0, 16'hF800);
      wait_done(2000, "slow_done");
      check_int("slow_count", q_bytes.size(), 13);
      check_hdr("slow", hdr);
      check_int("slow_col_hi", (q_bytes.size() > 11) ? int'(q_bytes[11]) : -1, 9'h1F8);
      min_gap = 1000;
      for (int i = 1; i < q_cyc.size(); i++)
         if (q_cyc[i] - q_cyc[i-1] < min_gap) min_gap = q_cyc[i] - q_cyc[i-1];
      check_int("slow_gap_ok", int'(min_gap >= 18), 1);
   endtask

   task automatic test_reset_abort();
      int n;
      int sz;
      int d0;
      q_bytes.delete(); q_cyc.delete();
      spi_k = 1;
      pulse_start(9'd0, 9'd3, 9'd0, 9'd3, 16'h5555);
      n = 0;
      while (q_bytes.size() < 15 && n < 500) begin
         @(posedge clk);
         n++;
      end
      check_int("abort_reached_pixels", int'(q_bytes.size() >= 15), 1);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      sz = q_bytes.size();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check_int("abort_no_strobes", q_bytes.size(), sz);
      check_int("abort_busy", int'(busy), 0);

      q_bytes.delete(); q_cyc.delete();
      d0 = done_cnt;
      @(posedge clk); #1;
      pulse_start(9'd1, 9'd2, 9'd3, 9'd4, 16'h1234);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         pulse_start(9'd0, 9'd239, 9'd0, 9'd319, 16'hFFFF);
      end
      wait_done(2000, "new_done");
      repeat (30) @(posedge clk);
      @(negedge clk);
      check_int("new_count", q_bytes.size(), 19);
      check_int("new_first", (q_bytes.size() > 0) ? int'(q_bytes[0]) : -1, 9'h02A);
      check_int("new_last_hi", (q_bytes.size() > 1) ? int'(q_bytes[q_bytes.size()-2]) : -1, 9'h112);
      check_int("new_last_lo", (q_bytes.size() > 0) ? int'(q_bytes[q_bytes.size()-1]) : -1, 9'h134);
      check_int("new_done_pulses", done_cnt - d0, 1);
      check_int("new_busy_after", int'(busy), 0);
   endtask

   initial begin
      total = 0; bad = 0; cyc = 0; spi_k = 0;
      done_cnt = 0; done_cyc = 0; busy_viol = 0; hold_err = 0; done_busy_err = 0;
      last_out = '0;
      rst = 1'b0; start = 1'b0;
      x0 = '0; x1 = '0; y0 = '0; y1 = '0; colour = '0;
      test_reset();
      test_single_pixel();
      test_reject();
      test_slow_spi();
      test_clamp_corner();
      test_clamp_stripe();
      test_reset_abort();
      check_int("strobe_while_busy", busy_viol, 0);
      check_int("data_hold", hold_err, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
